matrix_storage_reader: RTL and testbench

//  Read-side sequencer for the matrix storage bank; counterpart of the load-side locator.

---
 rtl/matrix_storage_pkg.sv | 16 +
 rtl/matrix_row_skid_buffer.sv | 63 ++++++
 rtl/matrix_storage_reader.sv | 126 ++++++++++++
 tb/tb_matrix_storage_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_storage_pkg.sv
// Shared widths, defaults and row metadata for the matrix storage read path.
package matrix_storage_pkg;

  localparam int unsigned IDX_W            = 32;
  localparam int unsigned DEFAULT_SIZE     = 3;
  localparam int unsigned DEFAULT_DATA_SET = 12;
  localparam int unsigned DEFAULT_ROW_W    = 96;
  localparam int unsigned CNT_W            = 2;

  // Metadata that travels alongside each row through the skid buffer.
  typedef struct packed {
    logic [IDX_W-1:0] layer;
    logic             last_row;
  } row_meta_t;

endpackage

// File: rtl/matrix_row_skid_buffer.sv
// Two-entry row FIFO with metadata; head is a mux of stored entries.
module matrix_row_skid_buffer
  import matrix_storage_pkg::*;
#(
  parameter int unsigned ROW_W = DEFAULT_ROW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ROW_W-1:0] push_data,
  input  row_meta_t        push_meta,
  input  logic             pop,
  output logic [ROW_W-1:0] head_data_c,
  output row_meta_t        head_meta_c,
  output logic [CNT_W-1:0] count
);

  logic [ROW_W-1:0] data_q [2];
  row_meta_t        meta_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(2)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= push_data;
      meta_q[wr_ptr_q] <= push_meta;
    end
  end

  assign head_data_c = data_q[rd_ptr_q];
  assign head_meta_c = meta_q[rd_ptr_q];
  assign count       = count_q;

endmodule

// File: rtl/matrix_storage_reader.sv
// Read-side sequencer: walks stored layers row by row and streams rows downstream,
// never issuing a layer before the load side has completed it.
module matrix_storage_reader
  import matrix_storage_pkg::*;
#(
  parameter int unsigned SIZE     = DEFAULT_SIZE,
  parameter int unsigned DATA_SET = DEFAULT_DATA_SET,
  parameter int unsigned ROW_W    = DEFAULT_ROW_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             layer_written,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_layer_index,
  output logic [IDX_W-1:0] rd_row_index,
  input  logic [ROW_W-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_data,
  output logic [IDX_W-1:0] out_layer,
  output logic             out_last_row,
  output logic [IDX_W-1:0] layers_pending,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] ROW_LAST   = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] LAYER_LAST = IDX_W'(DATA_SET - 1);
  localparam logic [IDX_W-1:0] PEND_MAX   = IDX_W'(DATA_SET);

  logic [IDX_W-1:0] row_ptr_q,   row_ptr_d;
  logic [IDX_W-1:0] layer_ptr_q, layer_ptr_d;
  logic [IDX_W-1:0] pending_q,   pending_d;
  logic             overflow_q,  overflow_d;
  logic             inflight_q;
  row_meta_t        inflight_meta_q;

  logic [CNT_W-1:0] buf_count;
  logic [ROW_W-1:0] buf_head_data;
  row_meta_t        buf_head_meta;
  row_meta_t        out_meta;
  logic [2:0]       occupancy;
  logic             credit_ok;
  logic             issue;
  logic             last_issue;
  logic             buf_empty;
  logic             buf_push;
  logic             buf_pop;

  // Two row slots in total: buffered rows plus the one returning from storage.
  assign occupancy  = 3'(buf_count) + 3'(inflight_q);
  assign credit_ok  = occupancy < 3'd2;
  assign issue      = !reset && ((row_ptr_q != '0) || (pending_q != '0)) && credit_ok;
  assign last_issue = issue && (row_ptr_q == ROW_LAST);

  always_comb begin
    row_ptr_d   = row_ptr_q;
    layer_ptr_d = layer_ptr_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    if (issue) begin
      if (row_ptr_q == ROW_LAST) begin
        row_ptr_d   = '0;
        layer_ptr_d = (layer_ptr_q == LAYER_LAST) ? '0 : layer_ptr_q + IDX_W'(1);
      end else begin
        row_ptr_d = row_ptr_q + IDX_W'(1);
      end
    end
    // Simultaneous write-complete and last-row issue cancel out.
    if (layer_written && !last_issue) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + IDX_W'(1);
    end else if (!layer_written && last_issue && (pending_q != '0)) begin
      pending_d = pending_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_ptr_q       <= '0;
      layer_ptr_q     <= '0;
      pending_q       <= '0;
      overflow_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_meta_q <= '0;
    end else begin
      row_ptr_q       <= row_ptr_d;
      layer_ptr_q     <= layer_ptr_d;
      pending_q       <= pending_d;
      overflow_q      <= overflow_d;
      inflight_q      <= issue;
      inflight_meta_q <= '{layer: layer_ptr_q, last_row: (row_ptr_q == ROW_LAST)};
    end
  end

  // A returning row bypasses the empty buffer; it is stored only if not taken.
  assign buf_empty = (buf_count == '0);
  assign buf_pop   = !buf_empty && out_ready;
  assign buf_push  = inflight_q && !(buf_empty && out_ready);

  matrix_row_skid_buffer #(
    .ROW_W (ROW_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push        (buf_push),
    .push_data   (rd_data),
    .push_meta   (inflight_meta_q),
    .pop         (buf_pop),
    .head_data_c (buf_head_data),
    .head_meta_c (buf_head_meta),
    .count       (buf_count)
  );

  assign out_meta       = buf_empty ? inflight_meta_q : buf_head_meta;
  assign out_data       = buf_empty ? rd_data : buf_head_data;
  assign out_layer      = out_meta.layer;
  assign out_last_row   = out_meta.last_row;
  assign out_valid      = !reset && (!buf_empty || inflight_q);

  assign rd_en          = issue;
  assign rd_layer_index = reset ? '0 : layer_ptr_q;
  assign rd_row_index   = reset ? '0 : row_ptr_q;
  assign layers_pending = reset ? '0 : pending_q;
  assign overflow       = !reset && overflow_q;

endmodule

// File: tb/tb_matrix_storage_reader.sv
// Scoreboard bench: acts as the storage bank and checks every streamed row.
module tb_matrix_storage_reader;
  import matrix_storage_pkg::*;

  localparam int unsigned SIZE     = 3;
  localparam int unsigned DATA_SET = 12;
  localparam int unsigned ROW_W    = 96;

  logic             clk = 1'b0;
  logic             reset;
  logic             layer_written;
  logic             rd_en;
  logic [31:0]      rd_layer_index;
  logic [31:0]      rd_row_index;
  logic [ROW_W-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_data;
  logic [31:0]      out_layer;
  logic             out_last_row;
  logic [31:0]      layers_pending;
  logic             overflow;

  always #5 clk = ~clk;

  matrix_storage_reader #(
    .SIZE     (SIZE),
    .DATA_SET (DATA_SET),
    .ROW_W    (ROW_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .layer_written  (layer_written),
    .rd_en          (rd_en),
    .rd_layer_index (rd_layer_index),
    .rd_row_index   (rd_row_index),
    .rd_data        (rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_layer      (out_layer),
    .out_last_row   (out_last_row),
    .layers_pending (layers_pending),
    .overflow       (overflow)
  );

  typedef struct {
    logic [ROW_W-1:0] data;
    logic [31:0]      layer;
    logic             last;
  } exp_row_t;

  exp_row_t    sb_q[$];
  int          n_vec = 0;
  int          n_miscmp = 0;
  int          rd_cnt = 0;
  int          out_cnt = 0;
  int unsigned m_layer = 0;
  int unsigned m_row = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_layer();
    layer_written = 1'b1;
    cyc();
    layer_written = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int idle = 0;
    for (int i = 0; i < max_cycles && idle < 4; i++) begin
      @(negedge clk);
      if (!rd_en && !out_valid) idle++;
      else idle = 0;
      cyc();
    end
    check("drain_done", 128'(idle >= 4), 128'(1));
    check("sb_empty", 128'(sb_q.size()), 128'(0));
  endtask

  // Storage model and scoreboard: index check on issue, data returned one cycle later.
  initial begin
    exp_row_t         e;
    logic             rd_pend;
    logic [ROW_W-1:0] rd_next;
    rd_data = '0;
    rd_next = '0;
    forever begin
      @(negedge clk);
      rd_pend = 1'b0;
      if (reset) begin
        sb_q.delete();
        m_layer = 0;
        m_row   = 0;
      end else begin
        if (out_valid && out_ready) begin
          check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_data", 128'(out_data), 128'(e.data));
            check("out_layer", 128'(out_layer), 128'(e.layer));
            check("out_last_row", 128'(out_last_row), 128'(e.last));
          end
          out_cnt++;
        end
        if (rd_en) begin
          check("rd_layer_index", 128'(rd_layer_index), 128'(m_layer));
          check("rd_row_index", 128'(rd_row_index), 128'(m_row));
          rd_next = {$urandom, $urandom, $urandom};
          e.data  = rd_next;
          e.layer = m_layer;
          e.last  = (m_row == SIZE - 1);
          sb_q.push_back(e);
          rd_pend = 1'b1;
          rd_cnt++;
          if (m_row == SIZE - 1) begin
            m_row   = 0;
            m_layer = (m_layer == DATA_SET - 1) ? 0 : m_layer + 1;
          end else begin
            m_row++;
          end
        end
      end
      cyc();
      rd_data = rd_pend ? rd_next : {$urandom, $urandom, $urandom};
    end
  end

  initial begin
    logic [5:0] exp_rd;
    logic [5:0] exp_ov;
    int         r0;
    int         o0;

    reset = 1'b1;
    layer_written = 1'b0;
    out_ready = 1'b0;

    // Reset state, including combinational forcing while reset is high.
    cyc();
    @(negedge clk);
    check("rst_rd_en", 128'(rd_en), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_pending", 128'(layers_pending), 128'(0));
    check("rst_rd_layer", 128'(rd_layer_index), 128'(0));
    check("rst_rd_row", 128'(rd_row_index), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 128'(out_valid), 128'(0));
    check("post_rst_pending", 128'(layers_pending), 128'(0));

    // Idle with nothing written.
    r0 = rd_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      check("idle_rd_en", 128'(rd_en), 128'(0));
      check("idle_out_valid", 128'(out_valid), 128'(0));
    end
    check("idle_pending", 128'(layers_pending), 128'(0));
    cyc();
    check("idle_rd_cnt", 128'(rd_cnt - r0), 128'(0));

    // One layer: exact issue and output cycle pattern.
    r0 = rd_cnt;
    o0 = out_cnt;
    exp_rd = 6'b001110;
    exp_ov = 6'b011100;
    out_ready = 1'b1;
    layer_written = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("one_rd_en", 128'(rd_en), 128'(exp_rd[i]));
      check("one_out_valid", 128'(out_valid), 128'(exp_ov[i]));
      if (i == 2) check("one_pending_mid", 128'(layers_pending), 128'(1));
      cyc();
      layer_written = 1'b0;
    end
    @(negedge clk);
    check("one_pending_end", 128'(layers_pending), 128'(0));
    cyc();
    check("one_rd_cnt", 128'(rd_cnt - r0), 128'(3));
    check("one_out_cnt", 128'(out_cnt - o0), 128'(3));

    // Write completion coinciding with the last-row issue.
    r0 = rd_cnt;
    layer_written = 1'b1;
    cyc();
    layer_written = 1'b0;
    cyc();
    cyc();
    layer_written = 1'b1;
    @(negedge clk);
    check("coin_rd_en", 128'(rd_en), 128'(1));
    check("coin_rd_row", 128'(rd_row_index), 128'(2));
    check("coin_pending_before", 128'(layers_pending), 128'(1));
    cyc();
    layer_written = 1'b0;
    @(negedge clk);
    check("coin_pending_after", 128'(layers_pending), 128'(1));
    check("coin_next_row", 128'(rd_row_index), 128'(0));
    cyc();
    wait_idle(40);
    check("coin_rd_cnt", 128'(rd_cnt - r0), 128'(6));
    check("coin_pending_end", 128'(layers_pending), 128'(0));

    // Backpressure: two reads fill the slots, then output holds.
    r0 = rd_cnt;
    o0 = out_cnt;
    out_ready = 1'b0;
    pulse_layer();
    repeat (8) cyc();
    @(negedge clk);
    check("bp_rd_en", 128'(rd_en), 128'(0));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    check("bp_pending", 128'(layers_pending), 128'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      check("bp_hold_data", 128'(out_data), 128'(sb_q[0].data));
      check("bp_hold_layer", 128'(out_layer), 128'(sb_q[0].layer));
    end
    cyc();
    check("bp_rd_cnt", 128'(rd_cnt - r0), 128'(2));
    check("bp_out_cnt", 128'(out_cnt - o0), 128'(0));
    out_ready = 1'b1;
    wait_idle(40);
    check("bp_rd_total", 128'(rd_cnt - r0), 128'(3));
    check("bp_out_total", 128'(out_cnt - o0), 128'(3));

    // Random backpressure across several layers.
    r0 = rd_cnt;
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      layer_written = ((i % 9) == 0) && (i < 40);
      cyc();
    end
    layer_written = 1'b0;
    out_ready = 1'b1;
    wait_idle(100);
    check("rand_rd_cnt", 128'(rd_cnt - r0), 128'(15));
    check("rand_pending", 128'(layers_pending), 128'(0));

    // Fill all layers while stalled, overflow on one more, then full-rate drain.
    r0 = rd_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      layer_written = 1'b1;
      cyc();
    end
    layer_written = 1'b0;
    @(negedge clk);
    check("full_pending", 128'(layers_pending), 128'(12));
    check("full_no_overflow", 128'(overflow), 128'(0));
    cyc();
    pulse_layer();
    @(negedge clk);
    check("ovf_set", 128'(overflow), 128'(1));
    check("ovf_pending_hold", 128'(layers_pending), 128'(12));
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      check("stream_out_valid", 128'(out_valid), 128'(1));
      cyc();
    end
    wait_idle(40);
    check("full_rd_cnt", 128'(rd_cnt - r0), 128'(36));
    check("full_pending_end", 128'(layers_pending), 128'(0));
    check("ovf_sticky", 128'(overflow), 128'(1));

    // Reset mid-layer discards state; next layer restarts at L0/R0.
    layer_written = 1'b1;
    cyc();
    layer_written = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_en", 128'(rd_en), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_rd_layer", 128'(rd_layer_index), 128'(0));
    check("mid_rst_rd_row", 128'(rd_row_index), 128'(0));
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_out_valid", 128'(out_valid), 128'(0));
    check("mid_post_rd_en", 128'(rd_en), 128'(0));
    check("mid_post_overflow", 128'(overflow), 128'(0));
    check("mid_post_pending", 128'(layers_pending), 128'(0));
    cyc();
    r0 = rd_cnt;
    pulse_layer();
    wait_idle(40);
    check("mid_restart_rd_cnt", 128'(rd_cnt - r0), 128'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
